i2c_byte_master: RTL and testbench
==================================

# i2c_byte_master

Parametrised I2C master byte engine. It accepts one byte command per valid/ready handshake and can prepend a START (or repeated START) and append a STOP. It shifts 8 bits MSB-first plus the ACK bit at a programmable SCL rate, and returns the read byte and ACK status as a one-cycle response. It sits between the ADT7420 transaction sequencer and the open-drain pad logic. It drives active-low enables only and never drives a line high.

## Interface
Parameters:
- `CLK_DIV`, default 250: `clk` cycles per SCL quarter-period; SCL period = 4*CLK_DIV cycles; legal range 2..65535.

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset; **one clock; reset is synchronous and active-high**
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: engine idle and able to accept; transfer when both are high on a rising `clk`
- `cmd_start` in 1: prepend START (repeated START if bus already owned)
- `cmd_stop` in 1: append STOP after the ACK bit
- `cmd_read` in 1: 1 = read byte from slave; 0 = write `cmd_wdata`
- `cmd_ack` in 1: on read, 1 = master sends ACK (SDA low), 0 = NACK
- `cmd_wdata` in 8: byte to write
- `rsp_valid` out 1: one-cycle pulse when the command completes
- `rsp_rdata` out 8: byte read; holds until the next `rsp_valid`
- `rsp_nack` out 1: on write, 1 = slave NACKed; on read, 0; holds until the next `rsp_valid`
- `bus_owned` out 1: START issued without a following STOP
- `scl_oe` out 1: 1 = pull SCL low, 0 = release
- `sda_oe` out 1: 1 = pull SDA low, 0 = release
- `scl_in` in 1: sampled SCL pad
- `sda_in` in 1: sampled SDA pad (externally synchronised)

## Operation
- States: IDLE, START, DATA (bits 7..0), ACK, STOP. Each bit slot has 4 quarters Q0..Q3, each lasting CLK_DIV cycles, timed by a quarter counter and a bit index.
- Data/ACK slot:
  - SDA updated at Q0 entry.
  - SCL low in Q0–Q1, released in Q2–Q3.
  - `sda_in` sampled on the last cycle of Q2.
- START slot:
  - SDA released in Q0–Q2; SCL low in Q0–Q1 and released in Q2.
  - SDA pulled low at Q3 entry while SCL is high.
- STOP slot:
  - SDA low in Q0–Q2; SCL released from Q2.
  - SDA released at Q3 entry.
- After accept the engine takes the path START (if `cmd_start`) → DATA → ACK → STOP (if `cmd_stop`) → IDLE. Command fields are latched at accept.
- Write command:
  - `sda_oe = ~wdata[bit]` for each data bit.
  - SDA released in ACK; sampled `sda_in` becomes `rsp_nack`.
- Read command:
  - SDA released during DATA; samples shift in MSB-first.
  - In ACK, `sda_oe = cmd_ack`.
- NACK does not abort the command. A requested STOP is still generated; the sequencer decides recovery.
- Line state after completion:
  - STOP issued: `bus_owned=0`, SCL and SDA released.
  - No STOP: `bus_owned=1`, SCL held low (`scl_oe=1`), SDA released.
- Command without `cmd_start` while `bus_owned=0`: executed as given, with no protection. Sequencer responsibility.

## Timing
- Reset values:
  - `cmd_ready=1`, `rsp_valid=0`, `rsp_rdata=0x00`, `rsp_nack=0`, `bus_owned=0`, `scl_oe=0`, `sda_oe=0`.
  - State IDLE, counters 0.
- `cmd_ready` drops the cycle after accept and returns high in the same cycle `rsp_valid` pulses.
- A new command may be accepted on that cycle, so back-to-back bytes have zero idle cycles.
- Latency from the accept edge to `rsp_valid`: 4*CLK_DIV*(9 + `cmd_start` + `cmd_stop`) cycles.
- `rst` mid-operation releases both lines the next cycle. No STOP is generated, and `bus_owned` clears.
- `cmd_valid` while busy: ignored, no effect on the current transfer.

## Configuration
- `I2C_CLOCK_STRETCH_EN` defined:
  - In Q2 of every slot, the quarter counter freezes while `scl_in=0` after SCL is released.
  - Counting resumes on the first cycle `scl_in=1`.
  - Latency grows by the stretch length.
- Not defined: `scl_in` is unused and timing is exactly as specified.

## Test plan
- CLK_DIV=4, write 0xA5, start+stop, slave ACKs:
  - SDA at Q2 of bits 7..0 reads 1,0,1,0,0,1,0,1.
  - `rsp_valid` 176 cycles after accept, `rsp_nack=0`, `bus_owned=0`, both lines released.
- Read, no start/stop, bus owned, slave drives 0x3C, `cmd_ack=0`:
  - `rsp_rdata=0x3C`, SDA released in ACK, latency 144.
  - `bus_owned` stays 1 and `scl_oe=1` after completion.
- Write 0x90 with start, slave leaves SDA high in ACK, `cmd_stop=1`:
  - `rsp_nack=1`.
  - STOP still produced: SDA rises during SCL high.
- Back-to-back: second `cmd_valid` held high:
  - Accepted on the same cycle as the first `rsp_valid`.
  - Repeated START shows SDA falling while SCL is high, with no idle gap.
- Assert `rst` during DATA bit 4: next cycle `scl_oe=0`, `sda_oe=0`, `cmd_ready=1`, `bus_owned=0`.
- With `I2C_CLOCK_STRETCH_EN`, hold `scl_in` low for 37 cycles in bit 6 Q2: `rsp_valid` arrives exactly 37 cycles later than the unstretched run.

Source files
------------

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: I2C master byte engine (optional START, 8 data bits MSB-first, ACK, optional STOP).
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; fields latched on accept
//   cmd_start/stop/read/ack   prepend START, append STOP, read byte, master ACK on read
//   cmd_wdata                 byte to write
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata, rsp_nack       read byte / slave NACK, held until the next rsp_valid
//   bus_owned                 START issued with no following STOP
//   scl_oe, sda_oe            1 = pull line low, 0 = release
//   scl_in, sda_in            sampled pads
// Macro I2C_CLOCK_STRETCH_EN: freeze the quarter counter in Q2 while a slave holds SCL low.
module i2c_byte_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_ack,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       bus_owned,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);
  typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP} state_t;
  state_t      state_q, state_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic [1:0]  q_q, q_d;
  logic [2:0]  bit_q, bit_d;
  logic        stop_q, stop_d, rd_q, rd_d, ack_q, ack_d;
  logic [7:0]  wdata_q, wdata_d, sh_q, sh_d;
  logic        smp_q, smp_d;
  logic        ready_q, ready_d, rsp_valid_q, rsp_valid_d, nack_q, nack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        owned_q, owned_d, scl_q, scl_d, sda_q, sda_d;
  logic        freeze, tick, last, sample, done;
`ifdef I2C_CLOCK_STRETCH_EN
  // SCL is released throughout Q2, so a low pad here means a slave is stretching
  assign freeze = (state_q != IDLE) && (q_q == 2'd2) && !scl_in;
`else
  logic scl_unused;
  assign scl_unused = scl_in;
  assign freeze = 1'b0;
`endif
  assign tick   = (qcnt_q == 16'(CLK_DIV - 1)) && !freeze;
  assign last   = tick && (q_q == 2'd3);
  assign sample = (state_q != IDLE) && (q_q == 2'd2) && tick;
  assign done   = last && ((state_q == ACK && !stop_q) || state_q == STOP);
  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    q_d         = q_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    rd_d        = rd_q;
    ack_d       = ack_q;
    wdata_d     = wdata_q;
    sh_d        = sh_q;
    smp_d       = smp_q;
    owned_d     = owned_q;
    rdata_d     = rdata_q;
    nack_d      = nack_q;
    rsp_valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        state_d = cmd_start ? START : DATA;
        qcnt_d  = '0;
        q_d     = '0;
        bit_d   = 3'd7;
        stop_d  = cmd_stop;
        rd_d    = cmd_read;
        ack_d   = cmd_ack;
        wdata_d = cmd_wdata;
        owned_d = owned_q | cmd_start;
      end
    end else begin
      qcnt_d = tick ? '0 : qcnt_q + (freeze ? 16'd0 : 16'd1);
      q_d    = tick ? q_q + 2'd1 : q_q;
      if (sample && state_q == DATA) sh_d = {sh_q[6:0], sda_in};
      if (sample && state_q == ACK) smp_d = sda_in;
      if (last) begin
        case (state_q)
          START: state_d = DATA;
          DATA: begin
            state_d = (bit_q == 3'd0) ? ACK : DATA;
            bit_d   = bit_q - 3'd1;
          end
          ACK: state_d = stop_q ? STOP : IDLE;
          default: begin
            state_d = IDLE;
            owned_d = 1'b0;
          end
        endcase
      end
      if (done) begin
        rsp_valid_d = 1'b1;
        rdata_d     = rd_q ? sh_q : rdata_q;
        nack_d      = !rd_q && smp_q;
      end
    end
    // line drive is derived from the next state so it changes on the slot/quarter boundary edge
    ready_d = (state_d == IDLE);
    scl_d   = (state_d == IDLE) ? owned_d : (q_d < 2'd2);
    sda_d   = (state_d == START) ? (q_d == 2'd3) :
              (state_d == DATA)  ? (!rd_d && !wdata_d[bit_d]) :
              (state_d == ACK)   ? (rd_d && ack_d) :
              (state_d == STOP)  ? (q_d != 2'd3) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      qcnt_q      <= '0;
      q_q         <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      rd_q        <= 1'b0;
      ack_q       <= 1'b0;
      wdata_q     <= '0;
      sh_q        <= '0;
      smp_q       <= 1'b0;
      owned_q     <= 1'b0;
      rdata_q     <= '0;
      nack_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      scl_q       <= 1'b0;
      sda_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      q_q         <= q_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      rd_q        <= rd_d;
      ack_q       <= ack_d;
      wdata_q     <= wdata_d;
      sh_q        <= sh_d;
      smp_q       <= smp_d;
      owned_q     <= owned_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
    end
  end
  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_nack  = nack_q;
  assign bus_owned = owned_q;
  assign scl_oe    = scl_q;
  assign sda_oe    = sda_q;
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: scoreboard bench for i2c_byte_master with a timing-based slave model.
module tb_i2c_byte_master;
  localparam int CD = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_start = 1'b0, cmd_stop = 1'b0, cmd_read = 1'b0, cmd_ack = 1'b0;
  logic [7:0] cmd_wdata = '0;
  logic cmd_ready, rsp_valid, rsp_nack, bus_owned, scl_oe, sda_oe, scl_in, sda_in;
  logic [7:0] rsp_rdata;
  logic slave_pull = 1'b0, stretch_hold = 1'b0, owned_m = 1'b0;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [7:0] rdata; logic nack; int lat; logic owned;} exp_t;
  exp_t sb[$];
  i2c_byte_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read), .cmd_ack(cmd_ack),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .bus_owned(bus_owned), .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in)
  );
  assign sda_in = ~sda_oe & ~slave_pull;
  assign scl_in = ~scl_oe & ~stretch_hold;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic run_cmd(input logic st, input logic sp, input logic rd, input logic ak,
                         input logic [7:0] wd, input logic [7:0] sbyte, input logic sack,
                         input logic b2b, input logic hold, input int abort_at, input int stretch_at);
    exp_t e;
    int n, c, ec, slot, d0, l;
    logic [7:0] seen;
    e.rdata = sbyte;
    e.nack  = !rd && !sack;
    e.lat   = 4 * CD * (9 + int'(st) + int'(sp)) + (stretch_at >= 0 ? 37 : 0);
    e.owned = sp ? 1'b0 : (st | owned_m);
    owned_m = e.owned;
    sb.push_back(e);
    if (b2b) check("b2b_ready", cmd_ready, 1);
    cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_ack = ak; cmd_wdata = wd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check("accept", cmd_ready, 1);
    @(posedge clk); #1;
    if (hold) begin
      cmd_wdata = ~wd; cmd_read = ~rd; cmd_start = ~st; cmd_stop = ~sp;
    end else cmd_valid = 1'b0;
    check("ready_drop", cmd_ready, 0);
    d0 = int'(st);
    l = 8 + int'(st) + int'(sp);
    seen = '0;
    c = 0;
    while (!rsp_valid && c < 5000) begin
      ec = (stretch_at < 0 || c < stretch_at) ? c : (c < stretch_at + 37 ? stretch_at : c - 37);
      stretch_hold = (stretch_at >= 0) && c >= stretch_at && c < stretch_at + 37;
      slot = ec / (4 * CD);
      slave_pull = (rd && slot >= d0 && slot < d0 + 8) ? ~sbyte[7 - (slot - d0)] :
                   (!rd && slot == d0 + 8) ? sack : 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; slave_pull = 1'b0; cmd_valid = 1'b0;
        check("abort_scl", scl_oe, 0);
        check("abort_sda", sda_oe, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_owned", bus_owned, 0);
        owned_m = 1'b0;
        void'(sb.pop_back());
        return;
      end
      if (ec % (4 * CD) == 3 * CD - 1) begin
        if (slot >= d0 && slot < d0 + 8) seen[7 - (slot - d0)] = sda_in;
        if (slot == d0 + 8) check("ack_sda_oe", sda_oe, rd & ak);
        if (st && slot == 0) begin check("start_q2_scl", scl_oe, 0); check("start_q2_sda", sda_oe, 0); end
        if (sp && slot == l) begin check("stop_q2_scl", scl_oe, 0); check("stop_q2_sda", sda_oe, 1); end
      end
      if (ec % (4 * CD) == 3 * CD) begin
        if (st && slot == 0) begin check("start_q3_scl", scl_oe, 0); check("start_q3_sda", sda_oe, 1); end
        if (sp && slot == l) begin check("stop_q3_scl", scl_oe, 0); check("stop_q3_sda", sda_oe, 0); end
      end
      @(posedge clk); #1;
      c++;
    end
    slave_pull = 1'b0;
    stretch_hold = 1'b0;
    e = sb.pop_front();
    check("latency", c, e.lat);
    if (!rd) check("wr_bits", seen, wd);
    if (rd) check("rdata", rsp_rdata, e.rdata);
    check("nack", rsp_nack, e.nack);
    check("owned", bus_owned, e.owned);
    check("scl_end", scl_oe, e.owned);
    check("sda_end", sda_oe, 0);
    check("ready_at_rsp", cmd_ready, 1);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_nack", rsp_nack, 0);
    check("rst_owned", bus_owned, 0);
    check("rst_scl", scl_oe, 0);
    check("rst_sda", sda_oe, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_cmd(1, 1, 0, 0, 8'hA5, 8'h00, 1, 0, 0, -1, -1);
    run_cmd(1, 0, 0, 0, 8'h91, 8'h00, 1, 0, 0, -1, -1);
    run_cmd(0, 0, 1, 0, 8'h00, 8'h3C, 0, 0, 0, -1, -1);
    run_cmd(0, 0, 1, 1, 8'h00, 8'h81, 0, 0, 0, -1, -1);
    run_cmd(1, 1, 0, 0, 8'h90, 8'h00, 0, 0, 0, -1, -1);
    run_cmd(1, 0, 0, 0, 8'h48, 8'h00, 1, 0, 1, -1, -1);
    run_cmd(1, 1, 0, 0, 8'h49, 8'h00, 1, 1, 0, -1, -1);
    run_cmd(1, 1, 0, 0, 8'h5A, 8'h00, 1, 0, 0, 4 * 4 * CD + 2, -1);
`ifdef I2C_CLOCK_STRETCH_EN
    run_cmd(1, 1, 0, 0, 8'hA5, 8'h00, 1, 0, 0, -1, 2 * 4 * CD + 2 * CD);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
